// File: rtl/sap2_pkg.sv
// Shared definitions for the SAP-2 memory subsystem: arbiter state encoding
// and default RAM address/data widths.
package sap2_pkg;

  localparam int unsigned SAP2_ADDR_W = 16;
  localparam int unsigned SAP2_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    CPU_ACC,
    CPU_RSP,
    LDR_ACC,
    LDR_RSP
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: CPU and loader request channels plus RAM port.
// The arbiter connects through the slave modport; its environment uses master.
interface mem_arbiter_if
  import sap2_pkg::*;
#(
  parameter int unsigned ADDR_W = SAP2_ADDR_W,
  parameter int unsigned DATA_W = SAP2_DATA_W
);

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ack;
  logic              cpu_stall;

  logic              ldr_req;
  logic              ldr_we;
  logic [ADDR_W-1:0] ldr_addr;
  logic [DATA_W-1:0] ldr_wdata;
  logic [DATA_W-1:0] ldr_rdata;
  logic              ldr_ack;

  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack, cpu_stall,
    input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
    output ldr_rdata, ldr_ack,
    output ram_en, ram_we, ram_addr, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack, cpu_stall,
    output ldr_req, ldr_we, ldr_addr, ldr_wdata,
    input  ldr_rdata, ldr_ack,
    input  ram_en, ram_we, ram_addr, ram_wdata,
    output ram_rdata
  );

endinterface

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between the SAP-2 CPU and the program loader.
// Optional macro MEM_ARB_STARVE_EN bounds consecutive loader wins over a waiting CPU.
module mem_arbiter
  import sap2_pkg::*;
#(
  parameter int unsigned ADDR_W     = SAP2_ADDR_W,
  parameter int unsigned DATA_W     = SAP2_DATA_W,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  arb_state_t        state, state_nx;
  logic              grant_cpu, grant_ldr, ldr_wins, starve_hit;
  logic              in_acc, ram_en, cpu_ack, ldr_ack;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [DATA_W-1:0] cpu_rdata_q, ldr_rdata_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    grant_cpu = 1'b0;
    grant_ldr = 1'b0;
    ldr_wins  = bus.ldr_req & ~(bus.cpu_req & starve_hit);
    case (state)
      IDLE: begin
        if (ldr_wins) begin
          grant_ldr = 1'b1;
          state_nx  = LDR_ACC;
        end else if (bus.cpu_req) begin
          grant_cpu = 1'b1;
          state_nx  = CPU_ACC;
        end
      end
      CPU_ACC: state_nx = CPU_RSP;
      CPU_RSP: state_nx = IDLE;
      LDR_ACC: state_nx = LDR_RSP;
      LDR_RSP: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Winner's command is frozen at the arbitration edge; requester inputs are
  // ignored until the FSM is back in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else if (grant_ldr) begin
      lat_we    <= bus.ldr_we;
      lat_addr  <= bus.ldr_addr;
      lat_wdata <= bus.ldr_wdata;
    end else if (grant_cpu) begin
      lat_we    <= bus.cpu_we;
      lat_addr  <= bus.cpu_addr;
      lat_wdata <= bus.cpu_wdata;
    end
  end

  // Outputs are masked by rst so a reset in the response cycle yields no ack.
  assign in_acc  = (state == CPU_ACC) || (state == LDR_ACC);
  assign ram_en  = in_acc & ~rst;
  assign cpu_ack = (state == CPU_RSP) & ~rst;
  assign ldr_ack = (state == LDR_RSP) & ~rst;

  assign bus.ram_en    = ram_en;
  assign bus.ram_we    = ram_en & lat_we;
  assign bus.ram_addr  = lat_addr;
  assign bus.ram_wdata = lat_wdata;
  assign bus.cpu_ack   = cpu_ack;
  assign bus.ldr_ack   = ldr_ack;
  assign bus.cpu_stall = bus.cpu_req & ~cpu_ack;

  // The registered RAM only presents read data in the response cycle, so the
  // read value is forwarded during ack and held in a register afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_rdata_q <= '0;
      ldr_rdata_q <= '0;
    end else begin
      if (cpu_ack && !lat_we) cpu_rdata_q <= bus.ram_rdata;
      if (ldr_ack && !lat_we) ldr_rdata_q <= bus.ram_rdata;
    end
  end

  assign bus.cpu_rdata = (cpu_ack && !lat_we) ? bus.ram_rdata : cpu_rdata_q;
  assign bus.ldr_rdata = (ldr_ack && !lat_we) ? bus.ram_rdata : ldr_rdata_q;

`ifdef MEM_ARB_STARVE_EN
  localparam int unsigned CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] starve_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (grant_cpu) begin
      starve_cnt <= '0;
    end else if (grant_ldr && bus.cpu_req && !starve_hit) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

  assign starve_hit = (starve_cnt == CNT_W'(STARVE_MAX));
`else
  assign starve_hit = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// CPU/loader traffic compared against a transaction-timing reference model.
module tb_mem_arbiter;
  import sap2_pkg::*;

  localparam int unsigned AW     = 16;
  localparam int unsigned DW     = 8;
  localparam int unsigned STARVE = 2;
`ifdef MEM_ARB_STARVE_EN
  localparam bit         STARVE_EN = 1'b1;
  localparam logic [5:0] ORDER_EXP = 6'b001001;
`else
  localparam bit         STARVE_EN = 1'b0;
  localparam logic [5:0] ORDER_EXP = 6'b000000;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(STARVE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // RAM environment: synchronous read, data one cycle after ram_en
  logic [DW-1:0] ram [0:65535];
  always @(posedge clk) begin
    if (bus.ram_en) begin
      if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_wdata;
      bus.ram_rdata <= ram[bus.ram_addr];
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: a grant at edge g means ram_en in cycle g, ack in g+1,
  // next arbitration no earlier than edge g+3; reset reopens arbitration.
  logic [DW-1:0] ref_mem [0:65535];
  int            e = 0;
  int            g_edge = -10;
  int            next_arb = 0;
  int unsigned   m_cnt = 0;
  bit            g_cpu, g_we;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0, m_cpu_rd = '0, m_ldr_rd = '0;

  bit         auto_on = 1'b0, hold_cpu = 1'b0, hold_ldr = 1'b0;
  logic [5:0] order;
  int         ng;
  int         c_ack_e, l_ack_e;

  logic [AW-1:0] pool [8] = '{16'h0000, 16'h0001, 16'h0100, 16'h0101,
                              16'h8000, 16'h8001, 16'hFFFE, 16'hFFFF};

  function automatic logic [AW-1:0] pick_addr();
    return pool[$urandom_range(0, 7)];
  endfunction

  task automatic step();
    logic          s_rst, s_cq, s_cwe, s_lq, s_lwe, lw;
    logic [AW-1:0] s_ca, s_la;
    logic [DW-1:0] s_cd, s_ld;
    bit            exp_en, exp_cack, exp_lack;
    s_rst = rst;
    s_cq = bus.cpu_req; s_cwe = bus.cpu_we; s_ca = bus.cpu_addr; s_cd = bus.cpu_wdata;
    s_lq = bus.ldr_req; s_lwe = bus.ldr_we; s_la = bus.ldr_addr; s_ld = bus.ldr_wdata;
    @(posedge clk);
    e++;
    if (s_rst) begin
      g_edge = -10; next_arb = e + 1; m_cnt = 0;
      m_addr = '0; m_wdata = '0; m_cpu_rd = '0; m_ldr_rd = '0;
    end else if (e >= next_arb) begin
      lw = s_lq && !(s_cq && STARVE_EN && m_cnt == STARVE);
      if (lw || s_cq) begin
        g_edge = e; next_arb = e + 3; g_cpu = !lw;
        g_we    = lw ? s_lwe : s_cwe;
        m_addr  = lw ? s_la : s_ca;
        m_wdata = lw ? s_ld : s_cd;
        if (lw && s_cq) m_cnt = (m_cnt == STARVE) ? m_cnt : m_cnt + 1;
        else if (!lw)   m_cnt = 0;
      end
    end
    #1;
    exp_en   = (g_edge == e);
    exp_cack = (g_edge == e - 1) && g_cpu;
    exp_lack = (g_edge == e - 1) && !g_cpu;
    if ((exp_cack || exp_lack) && g_we) ref_mem[m_addr] = m_wdata;
    if (exp_cack && !g_we) m_cpu_rd = ref_mem[m_addr];
    if (exp_lack && !g_we) m_ldr_rd = ref_mem[m_addr];
    chk("ram_en",    32'(bus.ram_en),    32'(exp_en));
    chk("ram_we",    32'(bus.ram_we),    32'(exp_en && g_we));
    chk("ram_addr",  32'(bus.ram_addr),  32'(m_addr));
    chk("ram_wdata", 32'(bus.ram_wdata), 32'(m_wdata));
    chk("cpu_ack",   32'(bus.cpu_ack),   32'(exp_cack));
    chk("ldr_ack",   32'(bus.ldr_ack),   32'(exp_lack));
    chk("cpu_rdata", 32'(bus.cpu_rdata), 32'(m_cpu_rd));
    chk("ldr_rdata", 32'(bus.ldr_rdata), 32'(m_ldr_rd));
    chk("cpu_stall", 32'(bus.cpu_stall), 32'(bus.cpu_req && !exp_cack));
    if (bus.cpu_ack === 1'b1 || bus.ldr_ack === 1'b1) begin
      if (ng < 6) order = {order[4:0], bus.cpu_ack};
      ng++;
    end
    if (bus.cpu_ack === 1'b1) c_ack_e = e;
    if (bus.ldr_ack === 1'b1) l_ack_e = e;
    if (exp_cack && !hold_cpu) bus.cpu_req = 1'b0;
    if (exp_lack && !hold_ldr) bus.ldr_req = 1'b0;
    if (auto_on) begin
      rst = ($urandom_range(0, 63) == 0);
      if (!bus.cpu_req && !exp_cack) begin
        if ($urandom_range(0, 2) == 0) begin
          bus.cpu_req = 1'b1; bus.cpu_we = 1'($urandom);
          bus.cpu_addr = pick_addr(); bus.cpu_wdata = DW'($urandom);
        end
      end else if (exp_en && g_cpu) begin
        bus.cpu_we = 1'($urandom); bus.cpu_addr = AW'($urandom); bus.cpu_wdata = DW'($urandom);
      end
      if (!bus.ldr_req && !exp_lack) begin
        if ($urandom_range(0, 1) == 0) begin
          bus.ldr_req = 1'b1; bus.ldr_we = 1'($urandom);
          bus.ldr_addr = pick_addr(); bus.ldr_wdata = DW'($urandom);
        end
      end else if (exp_en && !g_cpu) begin
        bus.ldr_we = 1'($urandom); bus.ldr_addr = AW'($urandom); bus.ldr_wdata = DW'($urandom);
      end
    end
  endtask

  task automatic wait_ack(input bit is_cpu, input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      seen = is_cpu ? (bus.cpu_ack === 1'b1) : (bus.ldr_ack === 1'b1);
    end
    chk(tag, 32'(seen), 32'd1);
  endtask

  initial begin
    logic [DW-1:0] v;
    for (int i = 0; i < 65536; i++) begin
      v = DW'($urandom);
      ram[i] <= v;
      ref_mem[i] = v;
    end
    ram[16'h0100] <= 8'h3C;
    ref_mem[16'h0100] = 8'h3C;

    rst = 1'b1;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.ldr_req = 1'b0; bus.ldr_we = 1'b0; bus.ldr_addr = '0; bus.ldr_wdata = '0;
    step();
    step();
    chk("rst_ram_en",   32'(bus.ram_en),    32'd0);
    chk("rst_ram_addr", 32'(bus.ram_addr),  32'd0);
    chk("rst_cpu_rd",   32'(bus.cpu_rdata), 32'd0);
    rst = 1'b0;
    step();

    // CPU read, loader idle
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0100;
    #1 chk("r030_stall_n", 32'(bus.cpu_stall), 32'd1);
    step();
    chk("r030_en",      32'(bus.ram_en),    32'd1);
    chk("r030_stall_n1", 32'(bus.cpu_stall), 32'd1);
    step();
    chk("r030_ack",     32'(bus.cpu_ack),   32'd1);
    chk("r030_rdata",   32'(bus.cpu_rdata), 32'h3C);
    chk("r030_stall_ack", 32'(bus.cpu_stall), 32'd0);
    step();

    // Loader write, then CPU read-back
    bus.ldr_req = 1'b1; bus.ldr_we = 1'b1; bus.ldr_addr = 16'h8000; bus.ldr_wdata = 8'hA5;
    wait_ack(1'b0, "r031_ldr_ack");
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h8000;
    wait_ack(1'b1, "r031_cpu_ack");
    chk("r031_rdata", 32'(bus.cpu_rdata), 32'hA5);
    step(); step();

    // Simultaneous requests: loader first, CPU three cycles later
    c_ack_e = -100; l_ack_e = -100;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h8000;
    bus.ldr_req = 1'b1; bus.ldr_we = 1'b0; bus.ldr_addr = 16'h0100;
    for (int i = 0; i < 15 && c_ack_e < 0; i++) step();
    chk("r032_gap", 32'(c_ack_e - l_ack_e), 32'd3);
    chk("r032_ldr_rd", 32'(bus.ldr_rdata), 32'h3C);
    step(); step();

    // Continuous loader pressure with CPU pending
    hold_cpu = 1'b1; hold_ldr = 1'b1; order = '0; ng = 0;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0001;
    bus.ldr_req = 1'b1; bus.ldr_we = 1'b0; bus.ldr_addr = 16'h0101;
    for (int i = 0; i < 40 && ng < 6; i++) step();
    chk("r033_count", 32'(ng >= 6), 32'd1);
    chk("r033_order", 32'(order), 32'(ORDER_EXP));
    hold_cpu = 1'b0; hold_ldr = 1'b0;
    repeat (9) step();
    bus.cpu_req = 1'b0; bus.ldr_req = 1'b0;
    repeat (4) step();

    // Reset during CPU_ACC aborts; request then completes
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0100;
    step();
    chk("r034_en", 32'(bus.ram_en), 32'd1);
    rst = 1'b1;
    step();
    chk("r034_no_ack", 32'(bus.cpu_ack),   32'd0);
    chk("r034_en0",    32'(bus.ram_en),    32'd0);
    chk("r034_addr0",  32'(bus.ram_addr),  32'd0);
    chk("r034_rd0",    32'(bus.cpu_rdata), 32'd0);
    rst = 1'b0;
    wait_ack(1'b1, "r034_ack");
    chk("r034_rdata", 32'(bus.cpu_rdata), 32'h3C);
    step(); step();

    auto_on = 1'b1;
    repeat (3000) step();
    auto_on = 1'b0;
    rst = 1'b0;
    repeat (10) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16, RAM address width (MAR high and low bytes).
REQ-002 Parameter DATA_W, default 8, RAM data width.
REQ-003 Parameter STARVE_MAX, default 8, maximum number of consecutive loader grants while cpu_req is pending (used only under REQ-024).
REQ-004 Ports shall be, one per line: name, direction, width, meaning.
- clk  in  1  single clock; all state changes on posedge.
- rst  in  1  reset, synchronous, active-high.
- cpu_req  in  1  CPU memory-cycle request, derived from RAM_LOAD, RAM_ENH or RAM_ENL of the control word; held until cpu_ack.
- cpu_we  in  1  1 = write (RAM_LOAD), 0 = read.
- cpu_addr  in  ADDR_W  MAR value.
- cpu_wdata  in  DATA_W  MDR value.
- cpu_rdata  out  DATA_W  read data; valid while cpu_ack=1 and held until the next CPU read.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_stall  out  1  freeze the controller stage counter.
- ldr_req  in  1  program-loader request; held until ldr_ack.
- ldr_we  in  1  loader write enable.
- ldr_addr  in  ADDR_W  loader address.
- ldr_wdata  in  DATA_W  loader write data.
- ldr_rdata  out  DATA_W  loader read data; same rules as cpu_rdata.
- ldr_ack  out  1  one-cycle completion pulse.
- ram_en  out  1  RAM access strobe.
- ram_we  out  1  RAM write strobe.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data; synchronous, valid one cycle after ram_en.

Function
REQ-005 The FSM shall have exactly five states: IDLE, CPU_ACC, CPU_RSP, LDR_ACC, LDR_RSP.
REQ-006 Arbitration shall take place only in IDLE; with no request pending, the FSM shall stay in IDLE.
REQ-007 In IDLE the FSM shall go to LDR_ACC if ldr_req=1 and the loader wins, else to CPU_ACC if cpu_req=1.
REQ-008 On the arbitration edge the winner's we, addr and wdata shall be latched into ram_we, ram_addr and ram_wdata.
REQ-009 In xxx_ACC: ram_en=1 and ram_we=latched we for exactly one cycle; the next state is xxx_RSP.
REQ-010 In xxx_RSP: ram_en=0 and ram_we=0; xxx_ack=1 for exactly one cycle; the next state is always IDLE.
REQ-011 On a read, ram_rdata shall be captured into xxx_rdata on the edge entering xxx_RSP.
REQ-012 On a write, xxx_rdata shall be unchanged.
REQ-013 Latency: request sampled at edge N -> ram_en high during cycle N+1 -> ack during cycle N+2.
REQ-014 Throughput: one transaction per 3 cycles at most.
REQ-015 A requester must drop req in the cycle after ack; a req still high in IDLE is a new request.
REQ-016 cpu_stall = cpu_req & ~cpu_ack (combinational), so the stage counter advances only on the ack cycle.
REQ-017 If both requests are present in IDLE, the loader shall win by default.
REQ-018 The FSM shall never assert both acks in the same cycle; ram_en shall never be high in two consecutive cycles.
REQ-019 Request inputs shall be ignored in all states except IDLE; req or address changes mid-transaction shall not alter ram_addr or ram_wdata.

Reset
REQ-020 While rst=1 at a posedge, the next state shall be IDLE, and ram_en, ram_we, cpu_ack, ldr_ack shall all be 0.
REQ-021 Reset shall also clear ram_addr, ram_wdata, cpu_rdata, ldr_rdata and the starvation counter to 0.
REQ-022 A reset during xxx_ACC or xxx_RSP shall abort the transaction with no ack; the requester's req shall be re-arbitrated after rst falls.
REQ-023 cpu_stall shall follow REQ-016 during reset.

Configuration
REQ-024 With macro MEM_ARB_STARVE_EN defined: a counter shall count loader grants made while cpu_req=1.
REQ-025 Under MEM_ARB_STARVE_EN, when the counter equals STARVE_MAX, the CPU shall win the next IDLE arbitration.
REQ-026 Under MEM_ARB_STARVE_EN, the counter shall clear on any CPU grant and saturate at STARVE_MAX.
REQ-027 Without MEM_ARB_STARVE_EN: strict loader priority; no counter logic shall be synthesized.

Structure
REQ-028 The state encoding (arb_state_t) and the ADDR_W/DATA_W defaults shall live in the shared package sap2_pkg.
REQ-029 No sub-module: the FSM, latches and counter shall be implemented inline.

Verification
REQ-030 CPU read with ldr_req=0, RAM[0x0100]=0x3C -> ram_en high at N+1; cpu_ack and cpu_rdata=0x3C at N+2; cpu_stall high at N and N+1.
REQ-031 Loader write 0xA5 to 0x8000, then CPU read of 0x8000 -> ldr_ack, then cpu_rdata=0xA5.
REQ-032 cpu_req and ldr_req rise together -> loader acked first, CPU acked 3 cycles later.
REQ-033 MEM_ARB_STARVE_EN, STARVE_MAX=2, ldr_req held continuously with cpu_req pending -> grant order L,L,C,L,L,C; without macro -> CPU never granted.
REQ-034 rst=1 during CPU_ACC -> no cpu_ack; state IDLE; all outputs 0; after rst falls the CPU request completes normally.
